// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared register-address width, default register count and x0 index.
package reg_scoreboard_pkg;
  localparam int REG_AW = 5;
  localparam int NREGS_DEF = 32;
  localparam int NSLOT = 2 ** REG_AW;
  localparam logic [REG_AW-1:0] X0 = '0;
endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode issue, writeback and hazard-status signals of the scoreboard.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;
  logic tick_tock;
  logic issue_valid;
  logic issue_regwrite;
  logic [REG_AW-1:0] issue_rd;
  logic [REG_AW-1:0] issue_rs1;
  logic [REG_AW-1:0] issue_rs2;
  logic wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic flush;
  logic rs1_busy;
  logic rs2_busy;
  logic stall;
  logic wb_err;
  modport master (
    output tick_tock, issue_valid, issue_regwrite, issue_rd, issue_rs1, issue_rs2,
    output wb_valid, wb_rd, flush,
    input rs1_busy, rs2_busy, stall, wb_err
  );
  modport slave (
    input tick_tock, issue_valid, issue_regwrite, issue_rd, issue_rs1, issue_rs2,
    input wb_valid, wb_rd, flush,
    output rs1_busy, rs2_busy, stall, wb_err
  );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: saturating up/down pending-write counter; clr dominates, inc+dec together hold.
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb
    cnt_d = clr_i                        ? '0 :
            (inc_i & ~dec_i & ~&cnt_q)   ? cnt_q + 1'b1 :
            (dec_i & ~inc_i & |cnt_q)    ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write scoreboard producing source-busy, stall and writeback-error.
// Optional SCOREBOARD_STATS_EN adds a saturating 32-bit stall-cycle counter output stall_cnt.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2,
  parameter int NREGS = NREGS_DEF
) (
  input logic clk,
  input logic rst,
  reg_scoreboard_if.slave sb
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  logic [CNT_W-1:0] cnt [NSLOT];
  logic rd_nz, wb_live, accept, retire, wb_err_q, wb_err_d;
  assign rd_nz = sb.issue_rd != X0;
  assign sb.rs1_busy = |cnt[sb.issue_rs1];
  assign sb.rs2_busy = |cnt[sb.issue_rs2];
  assign sb.stall = sb.issue_valid &
                    (sb.rs1_busy | sb.rs2_busy | (sb.issue_regwrite & rd_nz & (&cnt[sb.issue_rd])));
  assign accept = sb.issue_valid & sb.issue_regwrite & rd_nz & ~sb.stall;
  assign wb_live = sb.wb_valid & ~sb.tick_tock & (sb.wb_rd != X0);
  assign retire = wb_live & |cnt[sb.wb_rd];
  assign wb_err_d = wb_live & ~|cnt[sb.wb_rd];
  // x0 and addresses beyond NREGS have no storage and always read as idle
  for (genvar i = 0; i < NSLOT; i++) begin : g_reg
    if (i == 0 || i >= NREGS) begin : g_tie
      assign cnt[i] = '0;
    end else begin : g_cnt
      sb_counter #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc_i(accept & (sb.issue_rd == REG_AW'(i))),
        .dec_i(retire & (sb.wb_rd == REG_AW'(i))),
        .clr_i(sb.flush),
        .cnt_o(cnt[i])
      );
    end
  end
  always_ff @(posedge clk)
    if (rst) wb_err_q <= 1'b0;
    else wb_err_q <= wb_err_d;
  assign sb.wb_err = wb_err_q;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  always_comb stall_cnt_d = (sb.stall & ~&stall_cnt_q) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  always_ff @(posedge clk)
    if (rst) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed scenarios plus randomized traffic checked against a pending-count model.
module tb_reg_scoreboard;
  localparam int MAXC = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int pass_n = 0;
  int total_n = 0;
  int m_cnt [32];
  bit m_err = 1'b0;
  reg_scoreboard_if sbi ();
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt;
  longint m_sc = 0;
  reg_scoreboard dut (.clk(clk), .rst(rst), .sb(sbi), .stall_cnt(stall_cnt));
`else
  reg_scoreboard dut (.clk(clk), .rst(rst), .sb(sbi));
`endif
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  always @(negedge clk) begin
    bit e_stall, wbq, ret, acc;
    int rd, wr;
    rd = int'(sbi.issue_rd);
    wr = int'(sbi.wb_rd);
    e_stall = sbi.issue_valid && (m_cnt[sbi.issue_rs1] != 0 || m_cnt[sbi.issue_rs2] != 0 ||
              (sbi.issue_regwrite && rd != 0 && m_cnt[rd] == MAXC));
    if (!rst) begin
      chk("rs1_busy", sbi.rs1_busy, m_cnt[sbi.issue_rs1] != 0);
      chk("rs2_busy", sbi.rs2_busy, m_cnt[sbi.issue_rs2] != 0);
      chk("stall", sbi.stall, e_stall);
      chk("wb_err", sbi.wb_err, m_err);
`ifdef SCOREBOARD_STATS_EN
      chk("stall_cnt", stall_cnt, 32'(m_sc));
`endif
    end
    wbq = sbi.wb_valid && !sbi.tick_tock && wr != 0;
    ret = wbq && m_cnt[wr] != 0;
    acc = sbi.issue_valid && sbi.issue_regwrite && rd != 0 && !e_stall;
    if (rst) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_err = 1'b0;
`ifdef SCOREBOARD_STATS_EN
      m_sc = 0;
`endif
    end else begin
      m_err = wbq && m_cnt[wr] == 0;
`ifdef SCOREBOARD_STATS_EN
      if (e_stall && m_sc < 64'hFFFF_FFFF) m_sc++;
`endif
      if (sbi.flush) foreach (m_cnt[i]) m_cnt[i] = 0;
      else begin
        if (acc) m_cnt[rd]++;
        if (ret) m_cnt[wr]--;
      end
    end
  end

  task automatic put(input bit r, input bit fl, input bit iv, input bit iw, input int rd,
                     input int rs1, input int rs2, input bit wv, input int wrd, input bit tt);
    @(posedge clk);
    #1;
    rst = r;
    sbi.flush = fl;
    sbi.issue_valid = iv;
    sbi.issue_regwrite = iw;
    sbi.issue_rd = rd[4:0];
    sbi.issue_rs1 = rs1[4:0];
    sbi.issue_rs2 = rs2[4:0];
    sbi.wb_valid = wv;
    sbi.wb_rd = wrd[4:0];
    sbi.tick_tock = tt;
    @(negedge clk);
    #1;
  endtask

  initial begin
    foreach (m_cnt[i]) m_cnt[i] = 0;
    sbi.flush = 0; sbi.issue_valid = 0; sbi.issue_regwrite = 0; sbi.issue_rd = 0;
    sbi.issue_rs1 = 0; sbi.issue_rs2 = 0; sbi.wb_valid = 0; sbi.wb_rd = 0; sbi.tick_tock = 0;
    put(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    put(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    put(0, 0, 1, 1, 0, 13, 21, 0, 0, 0);
    chk("reset_rs1_busy", sbi.rs1_busy, 0);
    chk("reset_rs2_busy", sbi.rs2_busy, 0);
    chk("reset_stall", sbi.stall, 0);
    chk("reset_wb_err", sbi.wb_err, 0);
    put(0, 0, 1, 1, 5, 0, 0, 0, 0, 0);
    chk("issue5_stall", sbi.stall, 0);
    put(0, 0, 1, 0, 0, 5, 0, 0, 0, 0);
    chk("dep5_busy", sbi.rs1_busy, 1);
    chk("dep5_stall", sbi.stall, 1);
    put(0, 0, 1, 0, 0, 5, 0, 1, 5, 0);
    chk("wb5_nobypass", sbi.rs1_busy, 1);
    put(0, 0, 1, 0, 0, 5, 0, 0, 0, 0);
    chk("after_wb5_busy", sbi.rs1_busy, 0);
    chk("after_wb5_stall", sbi.stall, 0);
    for (int k = 0; k < 3; k++) begin
      put(0, 0, 1, 1, 7, 0, 0, 0, 0, 0);
      chk("fill7_stall", sbi.stall, 0);
    end
    put(0, 0, 1, 1, 7, 0, 0, 0, 0, 0);
    chk("sat7_stall", sbi.stall, 1);
    put(0, 0, 1, 1, 7, 0, 0, 1, 7, 0);
    chk("sat7_retire_stall", sbi.stall, 1);
    put(0, 0, 1, 1, 7, 0, 0, 0, 0, 0);
    chk("after_retire7_stall", sbi.stall, 0);
    put(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    put(0, 0, 1, 1, 9, 0, 0, 0, 0, 0);
    put(0, 0, 1, 1, 9, 0, 0, 1, 9, 0);
    chk("same9_stall", sbi.stall, 0);
    put(0, 0, 0, 0, 0, 0, 9, 0, 0, 0);
    chk("same9_rs2_busy", sbi.rs2_busy, 1);
    put(0, 0, 0, 0, 0, 0, 9, 1, 9, 0);
    put(0, 0, 0, 0, 0, 0, 9, 0, 0, 0);
    chk("drain9_rs2_busy", sbi.rs2_busy, 0);
    put(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("err12_pulse", sbi.wb_err, 1);
    put(0, 0, 0, 0, 0, 0, 0, 1, 12, 1);
    chk("err12_one_cycle", sbi.wb_err, 0);
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("err12_ticktock", sbi.wb_err, 0);
    put(0, 0, 1, 1, 3, 0, 0, 0, 0, 0);
    put(0, 0, 1, 1, 4, 0, 0, 0, 0, 0);
    put(0, 1, 1, 1, 6, 3, 4, 0, 0, 0);
    chk("flush_cur_busy", sbi.rs1_busy & sbi.rs2_busy, 1);
    put(0, 0, 1, 0, 0, 3, 4, 0, 0, 0);
    chk("flushed_rs1", sbi.rs1_busy, 0);
    chk("flushed_rs2", sbi.rs2_busy, 0);
    put(0, 0, 1, 0, 0, 6, 0, 0, 0, 0);
    chk("flushed_rd6", sbi.rs1_busy, 0);
    for (int k = 0; k < 5; k++) begin
      put(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      chk("rd0_nostall", sbi.stall, 0);
    end
    for (int k = 0; k < 4000; k++)
      put($urandom_range(0, 299) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7,
          $urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 11),
          $urandom_range(0, 11), $urandom_range(0, 1), $urandom_range(0, 7),
          $urandom_range(0, 3) == 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
